// File: rtl/branch_predictor_bht_pkg.sv
// Shared definitions for the IF-stage branch history table.
package branch_predictor_bht_pkg;

  // 2-bit saturating counter states; MSB is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Every table entry starts weakly not-taken.
  localparam ctr_e CTR_RST = WNT;

  // Default table index width (16 entries).
  localparam int unsigned BHT_IDX_W_DEF = 4;

endpackage

// File: rtl/branch_predictor_bht_if.sv
// Core <-> branch predictor signal bundle. The core side is the master.
interface branch_predictor_bht_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) ();

  logic             stall_i;
  logic [PC_W-1:0]  IF_PC_i;
  logic             IF_Branch_i;
  logic             ID_Branch_i;
  logic             ID_taken_i;
  logic             pred_taken_o;
  logic             ID_pred_taken_o;
  logic             mispredict_o;
  logic             ID_correct_pc_sel_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] miss_cnt_o;

  modport master (
    output stall_i, IF_PC_i, IF_Branch_i, ID_Branch_i, ID_taken_i,
    input  pred_taken_o, ID_pred_taken_o, mispredict_o,
           ID_correct_pc_sel_o, branch_cnt_o, miss_cnt_o
  );

  modport slave (
    input  stall_i, IF_PC_i, IF_Branch_i, ID_Branch_i, ID_taken_i,
    output pred_taken_o, ID_pred_taken_o, mispredict_o,
           ID_correct_pc_sel_o, branch_cnt_o, miss_cnt_o
  );

endinterface

// File: rtl/branch_predictor_bht_sat_counter2.sv
// Next-state function of a 2-bit saturating counter.
module sat_counter2
  import branch_predictor_bht_pkg::*;
(
  input  ctr_e cnt_i,
  input  logic en_i,
  input  logic inc_i,
  output ctr_e cnt_o
);

  // Step up on taken, down on not-taken, pinned at ST / SNT.
  always_comb begin
    cnt_o = cnt_i;
    if (en_i) begin
      if (inc_i) begin
        unique case (cnt_i)
          SNT:     cnt_o = WNT;
          WNT:     cnt_o = WT;
          WT:      cnt_o = ST;
          default: cnt_o = ST;
        endcase
      end else begin
        unique case (cnt_i)
          ST:      cnt_o = WT;
          WT:      cnt_o = WNT;
          WNT:     cnt_o = SNT;
          default: cnt_o = SNT;
        endcase
      end
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// IF-stage branch predictor: 2-bit counter table, IF/ID prediction carry,
// ID-stage mispredict detection, training and performance counters.
module branch_predictor_bht
  import branch_predictor_bht_pkg::*;
#(
  parameter int unsigned IDX_W = BHT_IDX_W_DEF,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_predictor_bht_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctr_e             bht_q [DEPTH];
  ctr_e             bht_d [DEPTH];
  logic             id_valid_q, id_valid_d;
  logic             id_pred_q,  id_pred_d;
  logic [IDX_W-1:0] id_idx_q,   id_idx_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q,   miss_cnt_d;

  logic [IDX_W-1:0] if_idx;
  ctr_e             rd_ctr;
  ctr_e             upd_ctr;
  logic             pred_taken;
  logic             resolve;
  logic             mispredict;
  logic             unused_pc_bits;

  assign if_idx         = bus.IF_PC_i[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.IF_PC_i[PC_W-1:IDX_W+2], bus.IF_PC_i[1:0]};

  // IF lookup and ID resolution, both combinational.
  always_comb begin
    rd_ctr     = bht_q[if_idx];
    pred_taken = bus.IF_Branch_i & rd_ctr[1];
    resolve    = id_valid_q & bus.ID_Branch_i & ~bus.stall_i;
    mispredict = resolve & (bus.ID_taken_i != id_pred_q);
  end

  assign bus.pred_taken_o        = pred_taken;
  assign bus.ID_pred_taken_o     = id_pred_q & id_valid_q;
  assign bus.mispredict_o        = mispredict;
  assign bus.ID_correct_pc_sel_o = mispredict & bus.ID_taken_i;
  assign bus.branch_cnt_o        = branch_cnt_q;
  assign bus.miss_cnt_o          = miss_cnt_q;

  // Single shared update path: only the entry carried into ID can train.
  sat_counter2 u_sat (
    .cnt_i (bht_q[id_idx_q]),
    .en_i  (resolve),
    .inc_i (bus.ID_taken_i),
    .cnt_o (upd_ctr)
  );

  // Table next state; the IF read above always sees the pre-update value.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      bht_d[i] = bht_q[i];
    end
    if (resolve) begin
      bht_d[id_idx_q] = upd_ctr;
    end
  end

  // IF/ID carry: stall holds, mispredict squashes the wrong-path IF slot.
  always_comb begin
    id_valid_d = id_valid_q;
    id_pred_d  = id_pred_q;
    id_idx_d   = id_idx_q;
    if (!bus.stall_i) begin
      if (mispredict) begin
        id_valid_d = 1'b0;
      end else begin
        id_valid_d = bus.IF_Branch_i;
        id_pred_d  = pred_taken;
        id_idx_d   = if_idx;
      end
    end
  end

  // Saturating performance counters.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (resolve && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + CNT_ONE;
    end
    if (mispredict && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + CNT_ONE;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bht_q[i] <= CTR_RST;
      end
      id_valid_q   <= 1'b0;
      id_pred_q    <= 1'b0;
      id_idx_q     <= '0;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bht_q[i] <= bht_d[i];
      end
      id_valid_q   <= id_valid_d;
      id_pred_q    <= id_pred_d;
      id_idx_q     <= id_idx_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht: a driver issues one cycle of
// stimulus at a time and queues the reference model's expected outputs; a
// monitor on the falling edge pops and compares.
module tb_branch_predictor_bht;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned NENT  = 2 ** IDX_W;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             pred;
    logic             id_pred;
    logic             mis;
    logic             sel;
    logic [CNT_W-1:0] bcnt;
    logic [CNT_W-1:0] mcnt;
  } exp_t;

  logic clk;
  logic rst_n;

  branch_predictor_bht_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  branch_predictor_bht #(.IDX_W(IDX_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  // Reference model: counter strength 0..3 per entry, plus the branch
  // sitting in ID (if any) with the prediction that went with it.
  int m_ctr [NENT];
  bit m_vld;
  bit m_pred;
  int m_idx;
  int m_bcnt;
  int m_mcnt;

  function automatic void model_reset();
    for (int i = 0; i < NENT; i++) m_ctr[i] = 1;
    m_vld  = 0;
    m_pred = 0;
    m_idx  = 0;
    m_bcnt = 0;
    m_mcnt = 0;
  endfunction

  // One clock of stimulus; expected outputs are those visible before the
  // next rising edge, then the model advances across that edge.
  task automatic cycle(input bit r, input bit stall, input int pc,
                       input bit ifb, input bit idb, input bit taken);
    exp_t e;
    int   idx;
    bit   p, res, mis;
    rst_n           = r;
    bus.stall_i     = stall;
    bus.IF_PC_i     = pc;
    bus.IF_Branch_i = ifb;
    bus.ID_Branch_i = idb;
    bus.ID_taken_i  = taken;
    if (!r) model_reset();
    idx = (pc / 4) % NENT;
    p   = ifb && (m_ctr[idx] >= 2);
    res = m_vld && idb && !stall && r;
    mis = res && (taken != m_pred);
    e.pred    = p;
    e.id_pred = m_vld && m_pred;
    e.mis     = mis;
    e.sel     = mis && taken;
    e.bcnt    = m_bcnt[CNT_W-1:0];
    e.mcnt    = m_mcnt[CNT_W-1:0];
    sb_q.push_back(e);
    if (r) begin
      if (res) begin
        if (taken) m_ctr[m_idx] = (m_ctr[m_idx] == 3) ? 3 : m_ctr[m_idx] + 1;
        else       m_ctr[m_idx] = (m_ctr[m_idx] == 0) ? 0 : m_ctr[m_idx] - 1;
        if (m_bcnt < CMAX) m_bcnt++;
        if (mis && m_mcnt < CMAX) m_mcnt++;
      end
      if (!stall) begin
        if (mis) m_vld = 0;
        else begin
          m_vld  = ifb;
          m_pred = p;
          m_idx  = idx;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // A branch fetched in IF, then resolved in ID with no new branch behind it.
  task automatic branch_once(input int pc, input bit outcome);
    cycle(1, 0, pc, 1, 0, 0);
    cycle(1, 0, pc + 4, 0, 1, outcome);
  endtask

  // Monitor: compare whenever an expectation is pending.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a.pred    = bus.pred_taken_o;
      a.id_pred = bus.ID_pred_taken_o;
      a.mis     = bus.mispredict_o;
      a.sel     = bus.ID_correct_pc_sel_o;
      a.bcnt    = bus.branch_cnt_o;
      a.mcnt    = bus.miss_cnt_o;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got pred=%b idp=%b mis=%b sel=%b bcnt=%0d mcnt=%0d, want pred=%b idp=%b mis=%b sel=%b bcnt=%0d mcnt=%0d",
                 $time, a.pred, a.id_pred, a.mis, a.sel, a.bcnt, a.mcnt,
                 e.pred, e.id_pred, e.mis, e.sel, e.bcnt, e.mcnt);
      end
    end
  end

  initial begin
    int pcs [4];
    bit idb;
    pcs[0] = 'h100; pcs[1] = 'h140; pcs[2] = 'h44; pcs[3] = 'h208;

    rst_n = 1'b0;
    bus.stall_i = 0; bus.IF_PC_i = '0; bus.IF_Branch_i = 0;
    bus.ID_Branch_i = 0; bus.ID_taken_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;

    // Reset state while still held, then the first mispredict at 0x40.
    cycle(0, 0, 'h40, 1, 0, 0);
    cycle(1, 0, 'h40, 1, 0, 0);
    cycle(1, 0, 'h40, 1, 1, 1);
    // Same PC twice more, both taken, then saturation.
    branch_once('h40, 1);
    branch_once('h40, 1);
    branch_once('h40, 1);

    // Loop pattern at 0x80: taken x3, not-taken x1, four times.
    for (int it = 0; it < 4; it++) begin
      for (int k = 0; k < 3; k++) branch_once('h80, 1);
      branch_once('h80, 0);
    end

    // Branch held in ID for three stalled cycles, resolves when stall drops.
    cycle(1, 0, 'h10, 1, 0, 0);
    for (int k = 0; k < 3; k++) cycle(1, 1, 'h14, 0, 1, 1);
    cycle(1, 0, 'h14, 0, 1, 1);
    cycle(1, 0, 'h18, 0, 0, 0);

    // Mispredict with a branch in IF: that branch is squashed.
    cycle(1, 0, 'h20, 1, 0, 0);
    cycle(1, 0, 'h24, 1, 1, 1);
    cycle(1, 0, 'h28, 0, 1, 1);
    cycle(1, 0, 'h2c, 0, 0, 0);

    // Aliasing: 0x100 and 0x140 share entry 0.
    branch_once('h140, 0);
    branch_once('h140, 0);
    cycle(1, 0, 'h100, 1, 0, 0);
    cycle(1, 0, 'h0, 0, 1, 1);
    branch_once('h100, 1);
    branch_once('h100, 1);
    cycle(1, 0, 'h140, 1, 0, 0);
    cycle(1, 0, 'h0, 0, 0, 0);

    // Decode disagreement: ID valid but ID_Branch_i low.
    cycle(1, 0, 'h44, 1, 0, 0);
    cycle(1, 0, 'h44, 1, 0, 1);
    cycle(1, 0, 'h0, 0, 1, 1);

    // Back-to-back correctly predicted branches drive branch_cnt to saturation.
    for (int k = 0; k < 65600; k++) cycle(1, 0, 'h200, 1, 1, 1);

    // Reset mid-run with a branch pending in ID.
    cycle(1, 0, 'h200, 1, 1, 0);
    cycle(0, 0, 'h200, 1, 1, 0);
    cycle(1, 0, 'h200, 1, 0, 0);
    cycle(1, 0, 'h0, 0, 1, 1);

    // Randomized traffic over a few aliasing PCs.
    for (int k = 0; k < 2000; k++) begin
      idb = m_vld;
      if ($urandom_range(0, 9) == 0) idb = !idb;
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 4) == 0),
            pcs[$urandom_range(0, 3)], ($urandom_range(0, 9) < 7),
            idb, ($urandom_range(0, 3) != 0));
    end

    repeat (3) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
